// File: rtl/inst_mem_loader.sv
// Loadable instruction memory. The program is streamed in over the load port,
// then served to the fetch stage over a valid/ready request/response interface.
// Reads are registered, and a small FIFO absorbs fetch-side backpressure.
module inst_mem_loader #(
  parameter int unsigned  A         = 10,
  parameter int unsigned  W         = 9,
  parameter int unsigned  DEPTH     = 3,
  parameter logic [W-1:0] HALT_WORD = '1
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Reload,
  input  logic         LoadValid,
  input  logic [W-1:0] LoadData,
  input  logic         LoadLast,
  output logic         LoadReady,
  input  logic         ReqValid,
  input  logic [A-1:0] ReqAddr,
  output logic         ReqReady,
  output logic         RespValid,
  output logic [W-1:0] RespData,
  output logic         RespOOR,
  input  logic         RespReady,
  output logic [A:0]   ProgLen,
  output logic         Loaded
);

  localparam int unsigned MemWords = 2 ** A;
  localparam int unsigned PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW     = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {StLoad, StRun} state_e;

  state_e state_q, state_d;

  logic [A-1:0] wr_ptr_q, wr_ptr_d;
  logic [A:0]   prog_len_q, prog_len_d;

  logic         load_acc, req_acc, last_word;
  logic         credit_ok;

  logic [W-1:0] mem [MemWords];
  logic [W-1:0] mem_rd_q;
  logic         rd_oor_q;
  logic         inflight_q;
  logic [W-1:0] rd_word;

  // Response FIFO entries hold {oor, word}.
  logic [W:0]      fifo_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, fw_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            fifo_push, fifo_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // FSM state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StLoad;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: leave LOAD on the last accepted word, Reload always returns to LOAD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StLoad:  if (load_acc && last_word) state_d = StRun;
      StRun:   if (Reload) state_d = StLoad;
      default: state_d = StLoad;
    endcase
  end

  // FSM outputs; ReqReady depends only on registered state and Reload.
  always_comb begin
    credit_ok = (32'(cnt_q) + 32'(inflight_q)) < DEPTH;
    LoadReady = (state_q == StLoad) && !Reload;
    ReqReady  = (state_q == StRun) && !Reload && credit_ok;
    Loaded    = (state_q == StRun);
  end

  assign load_acc  = LoadValid && LoadReady;
  assign req_acc   = ReqValid && ReqReady;
  assign last_word = LoadLast || (&wr_ptr_q);
  assign ProgLen   = prog_len_q;

  // Load pointer and program length next state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    prog_len_d = prog_len_q;
    if (Reload) begin
      wr_ptr_d   = '0;
      prog_len_d = '0;
    end else if (load_acc) begin
      wr_ptr_d = wr_ptr_q + A'(1);
      if (last_word) prog_len_d = {1'b0, wr_ptr_q} + (A + 1)'(1);
    end
  end

  assign rd_word = rd_oor_q ? HALT_WORD : mem_rd_q;

  // The freshly read word bypasses the FIFO when it is empty so a response is
  // visible the cycle after acceptance; it is only stored if not taken at once.
  assign fifo_pop  = (cnt_q != '0) && RespReady;
  assign fifo_push = inflight_q && !((cnt_q == '0) && RespReady);

  // Response head: FIFO entry if any, else the in-flight read.
  always_comb begin
    RespValid = 1'b0;
    RespData  = '0;
    RespOOR   = 1'b0;
    if (cnt_q != '0) begin
      RespValid           = 1'b1;
      {RespOOR, RespData} = fifo_q[rd_ptr_q];
    end else if (inflight_q) begin
      RespValid = 1'b1;
      RespData  = rd_word;
      RespOOR   = rd_oor_q;
    end
  end

  // Control registers; Reload flushes everything in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
      inflight_q <= 1'b0;
      rd_oor_q   <= 1'b0;
      rd_ptr_q   <= '0;
      fw_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      prog_len_q <= prog_len_d;
      if (Reload) begin
        inflight_q <= 1'b0;
        rd_oor_q   <= 1'b0;
        rd_ptr_q   <= '0;
        fw_ptr_q   <= '0;
        cnt_q      <= '0;
      end else begin
        inflight_q <= req_acc;
        if (req_acc) rd_oor_q <= ({1'b0, ReqAddr} >= prog_len_q);
        if (fifo_push) fw_ptr_q <= ptr_inc(fw_ptr_q);
        if (fifo_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        case ({fifo_push, fifo_pop})
          2'b10:   cnt_q <= cnt_q + CntW'(1);
          2'b01:   cnt_q <= cnt_q - CntW'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

  // Storage without reset: program memory, read register and FIFO entries.
  always_ff @(posedge Clk) begin
    if (load_acc) mem[wr_ptr_q] <= LoadData;
    if (req_acc) mem_rd_q <= mem[ReqAddr];
    if (fifo_push && !Reload) fifo_q[fw_ptr_q] <= {rd_oor_q, rd_word};
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader against a queue-based reference model.
module tb_inst_mem_loader;

  localparam int A     = 10;
  localparam int W     = 9;
  localparam int DEPTH = 3;
  localparam int NWORD = 1 << A;
  localparam logic [W-1:0] HALT = '1;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b1;
  logic         Reload = 1'b0;
  logic         LoadValid = 1'b0;
  logic [W-1:0] LoadData = '0;
  logic         LoadLast = 1'b0;
  logic         LoadReady;
  logic         ReqValid = 1'b0;
  logic [A-1:0] ReqAddr = '0;
  logic         ReqReady;
  logic         RespValid;
  logic [W-1:0] RespData;
  logic         RespOOR;
  logic         RespReady = 1'b0;
  logic [A:0]   ProgLen;
  logic         Loaded;

  inst_mem_loader dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Reload    (Reload),
    .LoadValid (LoadValid),
    .LoadData  (LoadData),
    .LoadLast  (LoadLast),
    .LoadReady (LoadReady),
    .ReqValid  (ReqValid),
    .ReqAddr   (ReqAddr),
    .ReqReady  (ReqReady),
    .RespValid (RespValid),
    .RespData  (RespData),
    .RespOOR   (RespOOR),
    .RespReady (RespReady),
    .ProgLen   (ProgLen),
    .Loaded    (Loaded)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Reference model: program image, length, and ordered expected responses.
  logic [W-1:0] ref_mem [NWORD];
  int           ref_len = 0;
  int           ref_wr = 0;
  bit           ref_run = 1'b0;
  logic [W:0]   exp_q [$];

  task automatic ref_reset();
    ref_run = 1'b0;
    ref_len = 0;
    ref_wr  = 0;
    exp_q.delete();
  endtask

  // Applies one clock edge of the specified behaviour to the model.
  task automatic model_edge();
    bit req_acc, load_acc, pop;
    if (Reload) begin
      ref_reset();
      return;
    end
    load_acc = !ref_run && LoadValid;
    req_acc  = ref_run && ReqValid && (exp_q.size() < DEPTH);
    pop      = (exp_q.size() > 0) && RespReady;
    if (pop) void'(exp_q.pop_front());
    if (req_acc) begin
      if (int'(ReqAddr) >= ref_len) exp_q.push_back({1'b1, HALT});
      else exp_q.push_back({1'b0, ref_mem[ReqAddr]});
    end
    if (load_acc) begin
      ref_mem[ref_wr] = LoadData;
      ref_wr++;
      if (LoadLast || ref_wr == NWORD) begin
        ref_len = ref_wr;
        ref_run = 1'b1;
      end
    end
  endtask

  task automatic finish_cycle();
    model_edge();
    @(posedge Clk);
    #1;
  endtask

  task automatic cycle();
    @(negedge Clk);
    finish_cycle();
  endtask

  task automatic pulse_reload();
    Reload = 1'b1;
    cycle();
    Reload = 1'b0;
  endtask

  // mode 0: random words, mode 1: word = address[8:0]
  task automatic load_seq(input int n, input bit use_last, input int mode);
    for (int i = 0; i < n; i++) begin
      LoadValid = 1'b1;
      LoadData  = (mode == 1) ? W'(i) : W'($urandom);
      LoadLast  = use_last && (i == n - 1);
      cycle();
    end
    LoadValid = 1'b0;
    LoadLast  = 1'b0;
  endtask

  task automatic test_reset();
    #3 Reset_n = 1'b0;
    #1;
    checks++;
    if ({RespValid, RespOOR, RespData, ProgLen, Loaded, ReqReady} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b oor=%b d=%h len=%0d ld=%b rr=%b, want all 0",
               RespValid, RespOOR, RespData, ProgLen, Loaded, ReqReady);
    end
    checks++;
    if (LoadReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_loadready: got %b want 1", LoadReady);
    end
    ref_reset();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_load_and_fetch();
    logic [W-1:0] words [5];
    words = '{9'h001, 9'h0AA, 9'h155, 9'h1FE, 9'h0F0};
    for (int i = 0; i < 5; i++) begin
      LoadValid = 1'b1;
      LoadData  = words[i];
      LoadLast  = (i == 4);
      @(negedge Clk);
      checks++;
      if (LoadReady !== 1'b1) begin
        errors++;
        $display("FAIL load_ready word %0d: got %b want 1", i, LoadReady);
      end
      finish_cycle();
    end
    LoadValid = 1'b0;
    LoadLast  = 1'b0;
    @(negedge Clk);
    checks++;
    if (ProgLen !== 11'd5 || Loaded !== 1'b1) begin
      errors++;
      $display("FAIL load5_done: got len=%0d loaded=%b want len=5 loaded=1", ProgLen, Loaded);
    end
    finish_cycle();
    RespReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ReqValid = (i < 5);
      ReqAddr  = A'(i);
      @(negedge Clk);
      if (i < 5) begin
        checks++;
        if (ReqReady !== 1'b1) begin
          errors++;
          $display("FAIL fetch_reqready addr %0d: got %b want 1", i, ReqReady);
        end
      end
      if (i > 0) begin
        checks++;
        if ({RespValid, RespOOR, RespData} !== {2'b10, words[i-1]}) begin
          errors++;
          $display("FAIL fetch_data addr %0d: got v=%b oor=%b d=%h want v=1 oor=0 d=%h",
                   i - 1, RespValid, RespOOR, RespData, words[i-1]);
        end
      end
      finish_cycle();
    end
    ReqValid = 1'b0;
  endtask

  task automatic test_oor();
    logic [A-1:0] addrs [2];
    addrs = '{10'd5, 10'd1023};
    RespReady = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ReqValid = 1'b1;
      ReqAddr  = addrs[i];
      cycle();
      ReqValid = 1'b0;
      @(negedge Clk);
      checks++;
      if ({RespValid, RespOOR, RespData} !== {2'b11, HALT}) begin
        errors++;
        $display("FAIL oor addr %0d: got v=%b oor=%b d=%h want v=1 oor=1 d=1ff",
                 addrs[i], RespValid, RespOOR, RespData);
      end
      finish_cycle();
    end
  endtask

  task automatic test_backpressure();
    int           acc = 0;
    logic [W-1:0] held = '0;
    bit           have_head = 1'b0;
    RespReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ReqValid = 1'b1;
      ReqAddr  = A'(i % 5);
      @(negedge Clk);
      checks++;
      if (ReqReady !== (exp_q.size() < DEPTH)) begin
        errors++;
        $display("FAIL bp_reqready cycle %0d: got %b want %b", i, ReqReady,
                 exp_q.size() < DEPTH);
      end
      if (ReqValid && ReqReady) acc++;
      if (have_head) begin
        checks++;
        if (RespValid !== 1'b1 || RespData !== held) begin
          errors++;
          $display("FAIL bp_head_held cycle %0d: got v=%b d=%h want v=1 d=%h",
                   i, RespValid, RespData, held);
        end
      end else if (RespValid === 1'b1) begin
        held      = RespData;
        have_head = 1'b1;
      end
      finish_cycle();
    end
    ReqValid = 1'b0;
    checks++;
    if (acc != 3) begin
      errors++;
      $display("FAIL bp_accept_count: got %0d want 3", acc);
    end
    RespReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checks++;
      if (exp_q.size() == 0 || RespValid !== 1'b1 || {RespOOR, RespData} !== exp_q[0]) begin
        errors++;
        $display("FAIL bp_drain %0d: got v=%b oor=%b d=%h, model queue size %0d",
                 i, RespValid, RespOOR, RespData, exp_q.size());
      end
      finish_cycle();
    end
    @(negedge Clk);
    checks++;
    if (ReqReady !== 1'b1 || RespValid !== 1'b0) begin
      errors++;
      $display("FAIL bp_resume: got rr=%b v=%b want rr=1 v=0", ReqReady, RespValid);
    end
    finish_cycle();
  endtask

  task automatic test_random_traffic();
    pulse_reload();
    load_seq(int'($urandom_range(1, 20)), 1'b1, 0);
    for (int i = 0; i < 300; i++) begin
      ReqValid  = ($urandom_range(0, 3) != 0);
      ReqAddr   = ($urandom_range(0, 7) == 0) ? A'($urandom) : A'($urandom_range(0, ref_len + 3));
      RespReady = ($urandom_range(0, 2) != 0);
      @(negedge Clk);
      checks++;
      if (ReqReady !== (ref_run && exp_q.size() < DEPTH)) begin
        errors++;
        $display("FAIL rnd_reqready cycle %0d: got %b want %b", i, ReqReady,
                 ref_run && exp_q.size() < DEPTH);
      end
      checks++;
      if (RespValid !== (exp_q.size() > 0)) begin
        errors++;
        $display("FAIL rnd_respvalid cycle %0d: got %b want %b", i, RespValid,
                 exp_q.size() > 0);
      end else if (exp_q.size() > 0) begin
        checks++;
        if ({RespOOR, RespData} !== exp_q[0]) begin
          errors++;
          $display("FAIL rnd_resp cycle %0d: got oor=%b d=%h want oor=%b d=%h", i,
                   RespOOR, RespData, exp_q[0][W], exp_q[0][W-1:0]);
        end
      end
      finish_cycle();
    end
    ReqValid  = 1'b0;
    RespReady = 1'b1;
    repeat (DEPTH + 1) cycle();
  endtask

  task automatic test_full_load();
    pulse_reload();
    load_seq(NWORD, 1'b0, 1);
    LoadValid = 1'b1;
    @(negedge Clk);
    checks++;
    if (Loaded !== 1'b1 || ProgLen !== 11'd1024 || LoadReady !== 1'b0) begin
      errors++;
      $display("FAIL full_load: got loaded=%b len=%0d lr=%b want 1 1024 0",
               Loaded, ProgLen, LoadReady);
    end
    finish_cycle();
    LoadValid = 1'b0;
    RespReady = 1'b1;
    ReqValid  = 1'b1;
    ReqAddr   = 10'd1023;
    cycle();
    ReqAddr = 10'd300;
    @(negedge Clk);
    checks++;
    if ({RespValid, RespOOR, RespData} !== {2'b10, HALT}) begin
      errors++;
      $display("FAIL full_fetch_1023: got v=%b oor=%b d=%h want v=1 oor=0 d=1ff",
               RespValid, RespOOR, RespData);
    end
    finish_cycle();
    ReqValid = 1'b0;
    @(negedge Clk);
    checks++;
    if ({RespValid, RespOOR, RespData} !== {2'b10, 9'h12C}) begin
      errors++;
      $display("FAIL full_fetch_300: got v=%b oor=%b d=%h want v=1 oor=0 d=12c",
               RespValid, RespOOR, RespData);
    end
    finish_cycle();
  endtask

  task automatic test_reload_flush();
    RespReady = 1'b0;
    ReqValid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ReqAddr = A'(i);
      cycle();
    end
    // Two responses buffered, one in flight: Reload together with a request.
    Reload = 1'b1;
    @(negedge Clk);
    checks++;
    if (ReqReady !== 1'b0 || RespValid !== 1'b1) begin
      errors++;
      $display("FAIL reload_same_cycle: got rr=%b v=%b want rr=0 v=1", ReqReady, RespValid);
    end
    finish_cycle();
    Reload   = 1'b0;
    ReqValid = 1'b0;
    @(negedge Clk);
    checks++;
    if (RespValid !== 1'b0 || Loaded !== 1'b0 || ProgLen !== '0 || LoadReady !== 1'b1) begin
      errors++;
      $display("FAIL reload_after: got v=%b loaded=%b len=%0d lr=%b want 0 0 0 1",
               RespValid, Loaded, ProgLen, LoadReady);
    end
    finish_cycle();
    // Reload beats a simultaneous load word.
    Reload    = 1'b1;
    LoadValid = 1'b1;
    @(negedge Clk);
    checks++;
    if (LoadReady !== 1'b0) begin
      errors++;
      $display("FAIL reload_vs_load: got lr=%b want 0", LoadReady);
    end
    finish_cycle();
    Reload    = 1'b0;
    LoadValid = 1'b0;
    load_seq(2, 1'b1, 0);
    RespReady = 1'b1;
    ReqValid  = 1'b1;
    ReqAddr   = 10'd2;
    cycle();
    ReqAddr = 10'd1;
    @(negedge Clk);
    checks++;
    if ({RespValid, RespOOR, RespData} !== {2'b11, HALT}) begin
      errors++;
      $display("FAIL reload_fetch2: got v=%b oor=%b d=%h want v=1 oor=1 d=1ff",
               RespValid, RespOOR, RespData);
    end
    finish_cycle();
    ReqValid = 1'b0;
    @(negedge Clk);
    checks++;
    if ({RespValid, RespOOR, RespData} !== {2'b10, ref_mem[1]}) begin
      errors++;
      $display("FAIL reload_fetch1: got v=%b oor=%b d=%h want v=1 oor=0 d=%h",
               RespValid, RespOOR, RespData, ref_mem[1]);
    end
    finish_cycle();
  endtask

  task automatic test_reset_midload();
    pulse_reload();
    load_seq(3, 1'b0, 0);
    #1 Reset_n = 1'b0;
    #1;
    checks++;
    if ({RespValid, RespOOR, RespData, ProgLen, Loaded, ReqReady} !== '0 ||
        LoadReady !== 1'b1) begin
      errors++;
      $display("FAIL midload_reset: got v=%b oor=%b d=%h len=%0d ld=%b rr=%b lr=%b",
               RespValid, RespOOR, RespData, ProgLen, Loaded, ReqReady, LoadReady);
    end
    ref_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    load_seq(2, 1'b1, 0);
    @(negedge Clk);
    checks++;
    if (ProgLen !== 11'd2 || Loaded !== 1'b1) begin
      errors++;
      $display("FAIL midload_restart: got len=%0d loaded=%b want 2 1", ProgLen, Loaded);
    end
    finish_cycle();
    RespReady = 1'b1;
    ReqValid  = 1'b1;
    ReqAddr   = 10'd0;
    cycle();
    ReqValid = 1'b0;
    @(negedge Clk);
    checks++;
    if ({RespValid, RespOOR, RespData} !== {2'b10, ref_mem[0]}) begin
      errors++;
      $display("FAIL midload_fetch0: got v=%b oor=%b d=%h want v=1 oor=0 d=%h",
               RespValid, RespOOR, RespData, ref_mem[0]);
    end
    finish_cycle();
  endtask

  initial begin
    test_reset();
    test_load_and_fetch();
    test_oor();
    test_backpressure();
    test_random_traffic();
    test_full_load();
    test_reload_flush();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Parametrised, loadable successor to the processor's instruction ROM.
- Program memory is filled at run time over a streaming load port, not by file init.
- Serves the fetch stage over a valid/ready request/response interface.
- Read is registered, with a small response buffer so the fetch stage can apply backpressure.
- Fetches past the loaded program length return a HALT word and are flagged.

Parameters:
A, 10, address bits; memory depth is 2**A words
W, 9, instruction word width
DEPTH, 3, response buffer entries; must be >= 3 for one fetch per cycle sustained
HALT_WORD, all ones (W bits), word returned for out-of-range fetches

Ports:
Clk  in  1  clock; all state updates on rising edge
Reset_n  in  1  asynchronous, active-low reset
Reload  in  1  single-cycle pulse; flushes and re-enters LOAD
LoadValid  in  1  load word present
LoadData  in  W  instruction word to write
LoadLast  in  1  qualifies LoadValid; marks the final program word
LoadReady  out  1  load word accepted when LoadValid && LoadReady
ReqValid  in  1  fetch request present
ReqAddr  in  A  fetch address
ReqReady  out  1  request accepted when ReqValid && ReqReady
RespValid  out  1  response data present
RespData  out  W  fetched instruction
RespOOR  out  1  response address was >= ProgLen
RespReady  in  1  consumer takes the response when RespValid && RespReady
ProgLen  out  A+1  number of words loaded
Loaded  out  1  high in RUN

Behaviour:
- Reset (async assert, sync deassert to Clk): state=LOAD, WrPtr=0, ProgLen=0, Loaded=0, RespValid=0, RespData=0, RespOOR=0, buffer empty, inflight=0. Memory contents are not reset.
- States: LOAD, RUN.
- LoadReady = (state==LOAD) && !Reload.
- ReqReady = (state==RUN) && !Reload && (occ+inflight < DEPTH). Depends only on registered state plus Reload; no path from RespReady.
- LOAD, on an accepted load word:
  - mem[WrPtr] <= LoadData; WrPtr <= WrPtr+1.
  - If LoadLast, or WrPtr == 2**A-1: ProgLen <= WrPtr+1, state <= RUN, Loaded <= 1 next cycle.
  - A full-depth load therefore yields ProgLen = 2**A, which is why ProgLen is A+1 bits.
- LOAD with no words accepted before LoadLast: ProgLen stays 0. A LoadLast-qualified word is always written (program length >= 1).
- RUN, on an accepted request at cycle t:
  - Synchronous memory read. The word, plus the OOR flag (ReqAddr >= ProgLen), enters the response buffer at end of t+1. RespValid is visible in cycle t+1 at the earliest.
  - inflight is 1 during t+1.
  - OOR responses carry RespData=HALT_WORD; memory data is ignored.
- Response buffer: FIFO of DEPTH entries, first-word-fall-through.
  - RespValid = (occ != 0); RespData/RespOOR come from the head entry.
  - Head is held stable while RespValid && !RespReady.
  - Push and pop may occur in the same cycle.
  - Responses return in request order; overflow is impossible by credit rule.
- Reload pulse (any state):
  - Next cycle: state=LOAD, WrPtr=0, ProgLen=0, Loaded=0, buffer and inflight flushed, RespValid=0.
  - Reload wins over a simultaneous LoadValid or ReqValid; neither is accepted (ready is 0 that cycle).
  - Memory contents are retained but are not fetchable until reloaded.
- Requests in LOAD are never accepted. Load words in RUN are never accepted.
- Reset_n asserted mid-load or mid-fetch behaves as the Reset bullet, immediately and asynchronously.
- ProgLen is stable throughout RUN.

Test Plan:
- Load 5 words 0x001,0x0AA,0x155,0x1FE,0x0F0 with LoadLast on the 5th. Expect ProgLen=5 and Loaded=1 one cycle later. With RespReady=1, fetch addresses 0..4 back-to-back: RespData in same order, each one cycle after acceptance, RespOOR=0, ReqReady held 1.
- After that load, fetch address 5 and then 1023. Expect RespData=0x1FF with RespOOR=1 for both.
- Hold RespReady=0 and issue requests each cycle. Expect exactly 3 accepted, ReqReady=0 after that, head RespData held constant. Release RespReady: 3 responses drain in order, then requests resume.
- Load 1024 words (value = address[8:0]) with no LoadLast. Expect auto-transition to RUN, ProgLen=1024, fetch 1023 returns 0x1FF with RespOOR=0.
- With 2 responses buffered and 1 in flight, pulse Reload together with ReqValid. Expect the request not accepted, RespValid=0 next cycle, state LOAD, ProgLen=0, LoadReady=1. Reload 2 words, then fetch address 2: HALT_WORD with OOR.
- Drop Reset_n mid-load after 3 words. Expect all outputs at reset values asynchronously. After release: LoadReady=1, WrPtr restarts at 0.
